// File: rtl/spi_receiver.sv
// ---------------------------------------------------------------------------
// spi_receiver
//
// Purpose:
//   SPI slave-side receiver. Watches ss/sclk, shifts miso into a word of
//   bitcount bits, and offers each completed word to a consumer through a
//   data_valid/data_ack handshake. A word that completes while the previous
//   one is still unacknowledged is dropped and flagged as an overrun. A frame
//   whose ss is released before bitcount samples raises a one-cycle
//   frame_error pulse.
//
// Optional build macro:
//   SPI_RECEIVER_SYNC_EN - when defined, ss/sclk/miso pass through two-flop
//   synchronisers (reset to their idle levels) before edge detection, adding
//   two clocks to every response. Use it for asynchronous external masters.
//   When undefined, the inputs must already be synchronous to clock.
//
// Ports:
//   clock        in   system clock, all logic on posedge
//   reset_n      in   asynchronous active-low reset
//   ss           in   slave select, active level set by ss_polarity
//   sclk         in   serial clock, idle level set by sclk_polarity
//   miso         in   serial data
//   data         out  last accepted word (bitcount bits)
//   data_valid   out  data holds an unacknowledged word
//   data_ack     in   consumer accepts data, clears data_valid
//   overrun      out  sticky: a completed word was dropped
//   overrun_clr  in   clears overrun
//   frame_error  out  one-cycle pulse: ss released before bitcount samples
//   busy         out  a frame is in progress
// ---------------------------------------------------------------------------
module spi_receiver #(
  parameter int bitcount      = 16,
  parameter bit ss_polarity   = 1'b0,
  parameter bit sclk_polarity = 1'b0,
  parameter bit sclk_phase    = 1'b0,
  parameter bit msb_first     = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ss,
  input  logic                sclk,
  input  logic                miso,
  output logic [bitcount-1:0] data,
  output logic                data_valid,
  input  logic                data_ack,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic                frame_error,
  output logic                busy
);

  // Counter is wide enough to hold bitcount itself, so it never wraps.
  localparam int CW = $clog2(bitcount + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(bitcount - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RECEIVE = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic                ss_raw;
  logic                sclk_raw;
  logic                miso_raw;
  logic                ss_i;
  logic                sclk_i;
  logic                miso_i;
  logic                prev_ss;
  logic                prev_sclk;
  logic                ss_rise;
  logic                leading_edge;
  logic                trailing_edge;
  logic                sample_edge;
  logic [1:0]          state;
  logic [CW-1:0]       bit_cnt;
  logic [bitcount-1:0] shift_reg;
  logic [bitcount-1:0] shift_next;
  logic                commit_pending;
  logic                word_dropped;

`ifdef SPI_RECEIVER_SYNC_EN
  logic [1:0] ss_sync;
  logic [1:0] sclk_sync;
  logic [1:0] miso_sync;

  // Synchronisers reset to idle levels so no edge is seen out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ss_sync   <= {2{~ss_polarity}};
      sclk_sync <= {2{sclk_polarity}};
      miso_sync <= 2'b00;
    end else begin
      ss_sync   <= {ss_sync[0], ss};
      sclk_sync <= {sclk_sync[0], sclk};
      miso_sync <= {miso_sync[0], miso};
    end
  end

  assign ss_raw   = ss_sync[1];
  assign sclk_raw = sclk_sync[1];
  assign miso_raw = miso_sync[1];
`else
  assign ss_raw   = ss;
  assign sclk_raw = sclk;
  assign miso_raw = miso;
`endif

  // Normalise: ss_i is active-high, sclk_i idles low.
  assign ss_i   = (ss_raw == ss_polarity);
  assign sclk_i = sclk_raw ^ sclk_polarity;
  assign miso_i = miso_raw;

  // Previous ss resets to active so a frame already running at reset
  // release is not mistaken for a new one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_ss   <= 1'b1;
      prev_sclk <= 1'b0;
    end else begin
      prev_ss   <= ss_i;
      prev_sclk <= sclk_i;
    end
  end

  assign ss_rise       = ss_i & ~prev_ss;
  assign leading_edge  = sclk_i & ~prev_sclk;
  assign trailing_edge = ~sclk_i & prev_sclk;
  assign sample_edge   = sclk_phase ? trailing_edge : leading_edge;

  // MSB-first pushes in at bit 0 so the first bit ends at the top;
  // LSB-first pushes in at the top so the first bit ends at bit 0.
  assign shift_next = msb_first
                    ? ((shift_reg << 1) | bitcount'(miso_i))
                    : ((shift_reg >> 1) | (bitcount'(miso_i) << (bitcount - 1)));

  // Frame state machine. The last sample arms commit_pending so the
  // handshake logic picks up the finished word on the following clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      commit_pending <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      frame_error    <= 1'b0;
      commit_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_rise) begin
            state     <= RECEIVE;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        RECEIVE: begin
          if (!ss_i) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end else if (sample_edge) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
              state          <= HOLD;
              commit_pending <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!ss_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A finished word is lost only if the previous one is still held and
  // not being acknowledged in the same cycle.
  assign word_dropped = commit_pending & data_valid & ~data_ack;

  // Output handshake: commit wins over a simultaneous ack, and a new
  // overrun wins over a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (commit_pending && !word_dropped) begin
        data       <= shift_reg;
        data_valid <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end

      if (word_dropped) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_receiver.sv
// ---------------------------------------------------------------------------
// tb_spi_receiver
//
// Purpose:
//   Self-checking bench for spi_receiver. Instance a uses the default
//   configuration (16 bits, CPOL=0, CPHA=0, MSB first); instance b uses
//   8 bits, CPOL=1, CPHA=1, LSB first. Expected handshake state comes from
//   a small transaction-level model (word complete -> accept or drop).
// ---------------------------------------------------------------------------
module tb_spi_receiver;

  logic clock = 1'b0;
  logic reset_n;

  logic        a_ss, a_sclk, a_miso, a_ack, a_clr;
  logic [15:0] a_data;
  logic        a_valid, a_ovr, a_fe, a_busy;

  logic        b_ss, b_sclk, b_miso, b_ack, b_clr;
  logic [7:0]  b_data;
  logic        b_valid, b_ovr, b_fe, b_busy;
  logic        b_fe_seen;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model of instance a's handshake outputs.
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ovr;

  typedef struct {
    logic [15:0] word;
    bit          ack_before;
    bit          clr_before;
    bit          ack_commit;
    bit          clr_commit;
    logic [15:0] exp_data;
    bit          exp_valid;
    bit          exp_ovr;
  } vec_t;

  vec_t vecs[6];

  always #5 clock = ~clock;

  spi_receiver u_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .ss          (a_ss),
    .sclk        (a_sclk),
    .miso        (a_miso),
    .data        (a_data),
    .data_valid  (a_valid),
    .data_ack    (a_ack),
    .overrun     (a_ovr),
    .overrun_clr (a_clr),
    .frame_error (a_fe),
    .busy        (a_busy)
  );

  spi_receiver #(
    .bitcount      (8),
    .ss_polarity   (1'b0),
    .sclk_polarity (1'b1),
    .sclk_phase    (1'b1),
    .msb_first     (1'b0)
  ) u_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .ss          (b_ss),
    .sclk        (b_sclk),
    .miso        (b_miso),
    .data        (b_data),
    .data_valid  (b_valid),
    .data_ack    (b_ack),
    .overrun     (b_ovr),
    .overrun_clr (b_clr),
    .frame_error (b_fe),
    .busy        (b_busy)
  );

  // Latch any frame_error pulse from instance b so short pulses are not missed.
  always @(negedge clock) begin
    if (b_fe === 1'b1) b_fe_seen = 1'b1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word completion as seen by the consumer: accepted if the slot is free
  // or being acked now, otherwise lost and flagged.
  task automatic model_commit(input logic [15:0] word, input bit ack, input bit clr);
    if (!m_valid || ack) begin
      m_data  = word;
      m_valid = 1'b1;
      if (clr) m_ovr = 1'b0;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic a_send_bits(input logic [15:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock) a_miso = word[15 - i];
      @(negedge clock) a_sclk = 1'b1;
      @(negedge clock) a_sclk = 1'b0;
    end
  endtask

  // Full 16-bit frame on instance a with optional handshake pulses around it.
  task automatic apply_stimulus(input string tag, input logic [15:0] word,
                                input bit ack_before, input bit clr_before,
                                input bit ack_commit, input bit clr_commit);
    if (ack_before || clr_before) begin
      @(negedge clock);
      a_ack = ack_before;
      a_clr = clr_before;
      @(negedge clock);
      a_ack = 1'b0;
      a_clr = 1'b0;
      if (ack_before) m_valid = 1'b0;
      if (clr_before) m_ovr = 1'b0;
      check_output({tag, " pre valid"}, a_valid, m_valid);
      check_output({tag, " pre overrun"}, a_ovr, m_ovr);
    end
    @(negedge clock) a_ss = 1'b0;
    a_send_bits(word, 15);
    check_output({tag, " busy mid"}, a_busy, 1'b1);
    @(negedge clock) a_miso = word[0];
    @(negedge clock) a_sclk = 1'b1;
    @(negedge clock);
    check_output({tag, " data before commit"}, a_data, m_data);
    check_output({tag, " valid before commit"}, a_valid, m_valid);
    a_ack  = ack_commit;
    a_clr  = clr_commit;
    a_sclk = 1'b0;
    model_commit(word, ack_commit, clr_commit);
    @(negedge clock);
    a_ack = 1'b0;
    a_clr = 1'b0;
    check_output({tag, " data"}, a_data, m_data);
    check_output({tag, " valid"}, a_valid, m_valid);
    check_output({tag, " overrun"}, a_ovr, m_ovr);
    check_output({tag, " frame_error"}, a_fe, 1'b0);
    check_output({tag, " busy hold"}, a_busy, 1'b1);
    @(negedge clock) a_ss = 1'b1;
    @(negedge clock);
    check_output({tag, " busy idle"}, a_busy, 1'b0);
  endtask

  // Instance b frame: CPOL=1 so leading edge goes low, sample on the rising
  // trailing edge; bits are sent LSB first.
  task automatic b_frame(input string tag, input logic [7:0] word, input int extra);
    @(negedge clock) b_ss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      b_miso = word[i];
      b_sclk = 1'b0;
      @(negedge clock) b_sclk = 1'b1;
    end
    @(negedge clock);
    @(negedge clock);
    check_output({tag, " data"}, b_data, word);
    check_output({tag, " valid"}, b_valid, 1'b1);
    for (int i = 0; i < extra; i++) begin
      @(negedge clock) b_sclk = 1'b0;
      @(negedge clock) b_sclk = 1'b1;
    end
    @(negedge clock);
    check_output({tag, " data after extra"}, b_data, word);
    check_output({tag, " busy hold"}, b_busy, 1'b1);
    check_output({tag, " overrun"}, b_ovr, 1'b0);
    @(negedge clock) b_ss = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_output({tag, " busy idle"}, b_busy, 1'b0);
    check_output({tag, " no frame_error"}, b_fe_seen, 1'b0);
  endtask

  initial begin
    logic [15:0] rword;
    logic [7:0]  rbyte;

    vecs[0] = '{16'hA5C3, 0, 0, 0, 0, 16'hA5C3, 1, 0};
    vecs[1] = '{16'h1234, 0, 0, 0, 0, 16'hA5C3, 1, 1};
    vecs[2] = '{16'h00FF, 0, 1, 1, 0, 16'h00FF, 1, 0};
    vecs[3] = '{16'hBEEF, 0, 0, 0, 1, 16'h00FF, 1, 1};
    vecs[4] = '{16'hFFFF, 1, 1, 0, 0, 16'hFFFF, 1, 0};
    vecs[5] = '{16'h0001, 1, 0, 0, 1, 16'h0001, 1, 0};

    reset_n = 1'b0;
    a_ss = 1'b1; a_sclk = 1'b0; a_miso = 1'b0; a_ack = 1'b0; a_clr = 1'b0;
    b_ss = 1'b1; b_sclk = 1'b1; b_miso = 1'b0; b_ack = 1'b0; b_clr = 1'b0;
    b_fe_seen = 1'b0;
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;

    repeat (3) @(negedge clock);
    check_output("reset data", a_data, 16'h0000);
    check_output("reset valid", a_valid, 1'b0);
    check_output("reset overrun", a_ovr, 1'b0);
    check_output("reset frame_error", a_fe, 1'b0);
    check_output("reset busy", a_busy, 1'b0);
    check_output("reset b data", b_data, 8'h00);
    reset_n = 1'b1;

    // Ack while nothing is held must leave data_valid low.
    @(negedge clock) a_ack = 1'b1;
    @(negedge clock) a_ack = 1'b0;
    check_output("idle ack valid", a_valid, 1'b0);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].word, vecs[i].ack_before,
                     vecs[i].clr_before, vecs[i].ack_commit, vecs[i].clr_commit);
      check_output($sformatf("vec%0d table data", i), a_data, vecs[i].exp_data);
      check_output($sformatf("vec%0d table valid", i), a_valid, vecs[i].exp_valid);
      check_output($sformatf("vec%0d table overrun", i), a_ovr, vecs[i].exp_ovr);
    end

    // Early ss release after 7 samples: one-cycle frame_error, word discarded.
    @(negedge clock) a_ss = 1'b0;
    a_send_bits(16'h5555, 7);
    @(negedge clock) a_ss = 1'b1;
    @(negedge clock);
    check_output("early frame_error", a_fe, 1'b1);
    check_output("early busy", a_busy, 1'b0);
    check_output("early valid", a_valid, m_valid);
    check_output("early data", a_data, m_data);
    @(negedge clock);
    check_output("early frame_error pulse end", a_fe, 1'b0);

    // Randomised frames against the model.
    for (int i = 0; i < 20; i++) begin
      rword = 16'($urandom);
      apply_stimulus($sformatf("rnd%0d", i), rword, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a frame, ss left active across release.
    @(negedge clock) a_ss = 1'b0;
    a_send_bits(16'hF0F0, 5);
    @(negedge clock) reset_n = 1'b0;
    #1;
    check_output("midreset data", a_data, 16'h0000);
    check_output("midreset valid", a_valid, 1'b0);
    check_output("midreset overrun", a_ovr, 1'b0);
    check_output("midreset frame_error", a_fe, 1'b0);
    check_output("midreset busy", a_busy, 1'b0);
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    a_send_bits(16'hFFFF, 16);
    @(negedge clock);
    @(negedge clock);
    check_output("after reset no capture valid", a_valid, 1'b0);
    check_output("after reset no capture busy", a_busy, 1'b0);
    @(negedge clock) a_ss = 1'b1;
    apply_stimulus("post reset", 16'h5A5A, 0, 0, 0, 0);

    // Instance b: CPOL=1, CPHA=1, LSB first, 8 bits.
    b_frame("b 0x81", 8'h81, 4);
    @(negedge clock) b_ack = 1'b1;
    @(negedge clock) b_ack = 1'b0;
    check_output("b ack valid", b_valid, 1'b0);
    rbyte = 8'($urandom);
    b_frame("b rnd", rbyte, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
